// File: rtl/transport_tx_scheduler_if.sv
// Signal bundle between the requesters/sender and the transport tx scheduler.
// The master side drives requests and sender status; the slave side is the scheduler.
interface transport_tx_scheduler_if;
    logic        ctrl_req;
    logic [15:0] ctrl_data;
    logic        ctrl_ack;
    logic        aud_valid;
    logic [15:0] aud_data;
    logic        aud_overflow;
    logic [1:0]  tx_cmd;
    logic [15:0] tx_data;
    logic        tx_busy;
    logic        tx_send;
    logic        tx_sending;
    logic        err_timeout;

    modport master (
        output ctrl_req, ctrl_data, aud_valid, aud_data, tx_busy, tx_sending,
        input  ctrl_ack, aud_overflow, tx_cmd, tx_data, tx_send, err_timeout
    );

    modport slave (
        input  ctrl_req, ctrl_data, aud_valid, aud_data, tx_busy, tx_sending,
        output ctrl_ack, aud_overflow, tx_cmd, tx_data, tx_send, err_timeout
    );
endinterface

// File: rtl/transport_tx_scheduler.sv
// Arbitrates control words and buffered audio samples onto the sender's single cmd/data
// input, one word per busy handshake, and schedules the sender's sendData pulses.
module transport_tx_scheduler #(
    parameter int AUD_DEPTH     = 8,
    parameter int CTRL_BURST    = 2,
    parameter int WORDS_PER_PKT = 7,
    parameter int BUSY_TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    transport_tx_scheduler_if.slave  io_bus
);

    localparam int PTR_W    = $clog2(AUD_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int TMO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam int STREAK_W = $clog2(CTRL_BURST + 1);
    localparam int WORDS_W  = $clog2(WORDS_PER_PKT + 1);

    typedef enum logic [1:0] {CMD_IDLE = 2'b00, CMD_CTRL = 2'b01, CMD_AUD = 2'b10} cmd_e;
    typedef enum logic [1:0] {G_IDLE, G_ISSUE, G_WAIT_HI, G_WAIT_LO} gstate_e;
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_HI, S_WAIT_LO} sstate_e;

    // Audio FIFO
    logic [15:0]         r_fifo [AUD_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_aud_overflow;

    // Grant FSM
    gstate_e             r_gstate;
    cmd_e                r_tx_cmd;
    logic [15:0]         r_tx_data;
    logic                r_ctrl_ack;
    logic                r_grant_aud;
    logic [TMO_W-1:0]    r_gtimer;
    logic [STREAK_W-1:0] r_ctrl_streak;
    logic [WORDS_W-1:0]  r_aud_words;

    // Send FSM
    sstate_e             r_sstate;
    logic [3:0]          r_owed;
    logic [TMO_W-1:0]    r_stimer;
    logic                r_tx_send;
    logic                r_err_timeout;

    logic w_fifo_full, w_fifo_empty, w_push, w_pop;
    logic w_decide, w_aud_win, w_ctrl_win, w_done, w_owe_send;
    logic w_g_timeout, w_s_timeout, w_s_start;

    assign w_fifo_full  = (r_count == CNT_W'(AUD_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = io_bus.aud_valid && !w_fifo_full;

    // The ack cycle is skipped so a requester that is still holding ctrl_req for the
    // word just acknowledged is not granted twice.
    assign w_decide   = (r_gstate == G_IDLE) && !io_bus.tx_busy && !r_ctrl_ack;
    assign w_aud_win  = !w_fifo_empty &&
                        (!io_bus.ctrl_req || r_ctrl_streak == STREAK_W'(CTRL_BURST));
    assign w_ctrl_win = io_bus.ctrl_req && !w_aud_win;
    assign w_pop      = w_decide && w_aud_win;

    assign w_done      = (r_gstate == G_WAIT_LO) && !io_bus.tx_busy;
    assign w_owe_send  = w_done &&
                         (!r_grant_aud || r_aud_words == WORDS_W'(WORDS_PER_PKT - 1));
    assign w_g_timeout = (r_gstate == G_WAIT_HI) && !io_bus.tx_busy &&
                         (r_gtimer == TMO_W'(BUSY_TIMEOUT - 1));
    assign w_s_timeout = (r_sstate == S_WAIT_HI) && !io_bus.tx_sending &&
                         (r_stimer == TMO_W'(BUSY_TIMEOUT - 1));
    assign w_s_start   = (r_sstate == S_IDLE) && (r_owed != 4'd0) && !io_bus.tx_sending;

    // NOTE: the sample storage has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= io_bus.aud_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_aud_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (io_bus.aud_valid && w_fifo_full) r_aud_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gstate      <= G_IDLE;
            r_tx_cmd      <= CMD_IDLE;
            r_tx_data     <= '0;
            r_ctrl_ack    <= 1'b0;
            r_grant_aud   <= 1'b0;
            r_gtimer      <= '0;
            r_ctrl_streak <= '0;
            r_aud_words   <= '0;
        end else begin
            r_ctrl_ack <= 1'b0;
            case (r_gstate)
                G_IDLE: begin
                    if (w_decide) begin
                        if (w_fifo_empty) r_ctrl_streak <= '0;
                        if (w_aud_win) begin
                            r_tx_cmd    <= CMD_AUD;
                            r_tx_data   <= r_fifo[r_rd_ptr];
                            r_grant_aud <= 1'b1;
                            r_gstate    <= G_ISSUE;
                        end else if (w_ctrl_win) begin
                            r_tx_cmd    <= CMD_CTRL;
                            r_tx_data   <= io_bus.ctrl_data;
                            r_grant_aud <= 1'b0;
                            r_gstate    <= G_ISSUE;
                        end
                    end
                end
                G_ISSUE: begin
                    r_tx_cmd <= CMD_IDLE;
                    r_gtimer <= '0;
                    r_gstate <= G_WAIT_HI;
                end
                G_WAIT_HI: begin
                    if (io_bus.tx_busy) begin
                        r_gstate <= G_WAIT_LO;
                    end else if (w_g_timeout) begin
                        // The word is dropped, but a control requester is still released.
                        r_ctrl_ack <= !r_grant_aud;
                        r_gstate   <= G_IDLE;
                    end else begin
                        r_gtimer <= r_gtimer + 1'b1;
                    end
                end
                G_WAIT_LO: begin
                    if (w_done) begin
                        r_gstate <= G_IDLE;
                        if (r_grant_aud) begin
                            r_ctrl_streak <= '0;
                            if (r_aud_words == WORDS_W'(WORDS_PER_PKT - 1))
                                r_aud_words <= '0;
                            else
                                r_aud_words <= r_aud_words + 1'b1;
                        end else begin
                            r_ctrl_ack <= 1'b1;
                            if (r_ctrl_streak != STREAK_W'(CTRL_BURST))
                                r_ctrl_streak <= r_ctrl_streak + 1'b1;
                        end
                    end
                end
                default: r_gstate <= G_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sstate  <= S_IDLE;
            r_owed    <= 4'd0;
            r_stimer  <= '0;
            r_tx_send <= 1'b0;
        end else begin
            case ({w_owe_send, w_s_start})
                2'b10:   if (r_owed != 4'hF) r_owed <= r_owed + 4'd1;
                2'b01:   r_owed <= r_owed - 4'd1;
                default: r_owed <= r_owed;
            endcase
            case (r_sstate)
                S_IDLE: begin
                    if (w_s_start) begin
                        r_tx_send <= 1'b1;
                        r_sstate  <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    r_tx_send <= 1'b0;
                    r_stimer  <= '0;
                    r_sstate  <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (io_bus.tx_sending)  r_sstate <= S_WAIT_LO;
                    else if (w_s_timeout)   r_sstate <= S_IDLE;
                    else                    r_stimer <= r_stimer + 1'b1;
                end
                S_WAIT_LO: begin
                    if (!io_bus.tx_sending) r_sstate <= S_IDLE;
                end
                default: r_sstate <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                           r_err_timeout <= 1'b0;
        else if (w_g_timeout || w_s_timeout) r_err_timeout <= 1'b1;
    end

    assign io_bus.ctrl_ack     = r_ctrl_ack;
    assign io_bus.aud_overflow = r_aud_overflow;
    assign io_bus.tx_cmd       = r_tx_cmd;
    assign io_bus.tx_data      = r_tx_data;
    assign io_bus.tx_send      = r_tx_send;
    assign io_bus.err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_transport_tx_scheduler.sv
// Bench for transport_tx_scheduler: sender/requester models at negedge, a queue of expected
// issues checked as the scheduler drives tx_cmd, and one task per scenario.
module tb_transport_tx_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    transport_tx_scheduler_if bus ();

    transport_tx_scheduler dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [17:0] exp_q [$];
    logic [15:0] ctrl_words [$];

    logic model_busy = 1'b0, busy_force = 1'b0, busy_en = 1'b1, issue_pend = 1'b0;
    logic model_sending = 1'b0, send_pend = 1'b0;
    int   busy_left = 0, sending_left = 0;
    int   n_issues = 0, n_sends = 0, n_acks = 0;
    int   last_issue_cyc = 0, last_send_cyc = 0, last_ack_cyc = 0;

    assign bus.tx_busy    = model_busy | busy_force;
    assign bus.tx_sending = model_sending;

    // Sender, packet shifter and control requester, all acting mid-cycle.
    always @(negedge clk) begin
        if (bus.tx_cmd != 2'b00) begin
            logic [17:0] exp_w;
            n_issues++;
            last_issue_cyc = cyc;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL issue: unexpected tx_cmd=%b tx_data=%h at cycle %0d",
                         bus.tx_cmd, bus.tx_data, cyc);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.tx_cmd, bus.tx_data} !== exp_w) begin
                    n_err++;
                    $display("FAIL issue: got cmd=%b data=%h, want cmd=%b data=%h",
                             bus.tx_cmd, bus.tx_data, exp_w[17:16], exp_w[15:0]);
                end
            end
            if (busy_en) issue_pend = 1'b1;
        end else if (issue_pend) begin
            issue_pend = 1'b0;
            model_busy = 1'b1;
            busy_left  = 4;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) model_busy = 1'b0;
        end

        if (bus.tx_send) begin
            n_sends++;
            last_send_cyc = cyc;
            send_pend = 1'b1;
        end else if (send_pend) begin
            send_pend     = 1'b0;
            model_sending = 1'b1;
            sending_left  = 3;
        end else if (sending_left > 0) begin
            sending_left--;
            if (sending_left == 0) model_sending = 1'b0;
        end

        if (bus.ctrl_ack) begin
            n_acks++;
            last_ack_cyc = cyc;
            if (ctrl_words.size() > 0) bus.ctrl_data = ctrl_words.pop_front();
            else                       bus.ctrl_req  = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ctrl_req  = 1'b0;
        bus.ctrl_data = '0;
        bus.aud_valid = 1'b0;
        bus.aud_data  = '0;
        busy_force = 1'b0;
        busy_en    = 1'b1;
        exp_q.delete();
        ctrl_words.delete();
        repeat (3) tick();
        model_busy = 1'b0;  issue_pend = 1'b0;  busy_left = 0;
        model_sending = 1'b0;  send_pend = 1'b0;  sending_left = 0;
        n_issues = 0;  n_sends = 0;  n_acks = 0;
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_drained(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d issues still outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.tx_cmd, bus.tx_data, bus.ctrl_ack, bus.tx_send, bus.err_timeout,
             bus.aud_overflow} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs: cmd=%b data=%h ack=%b send=%b err=%b ovf=%b, want all 0",
                     bus.tx_cmd, bus.tx_data, bus.ctrl_ack, bus.tx_send, bus.err_timeout,
                     bus.aud_overflow);
        end
    endtask

    task automatic test_ctrl_word();
        int k;
        do_reset();
        exp_q.push_back({2'b01, 16'hA5C3});
        bus.ctrl_data = 16'hA5C3;
        bus.ctrl_req  = 1'b1;
        k = 0;
        while (n_acks == 0 && k < 40) begin tick(); k++; end
        n_vec++;
        if (last_ack_cyc - last_issue_cyc != 6 || n_acks == 0) begin
            n_err++;
            $display("FAIL ctrl_ack_latency: acks=%0d issue->ack=%0d cycles, want 1 ack at 6",
                     n_acks, last_ack_cyc - last_issue_cyc);
        end
        repeat (20) tick();
        n_vec++;
        if (n_acks != 1) begin
            n_err++;
            $display("FAIL ctrl_ack_count: got %0d, want 1", n_acks);
        end
        n_vec++;
        if (n_sends != 1 || last_send_cyc <= last_ack_cyc) begin
            n_err++;
            $display("FAIL ctrl_send: sends=%0d send_cyc=%0d ack_cyc=%0d, want 1 send after ack",
                     n_sends, last_send_cyc, last_ack_cyc);
        end
        wait_drained("ctrl", 1);
    endtask

    task automatic test_audio_packet();
        do_reset();
        for (int i = 1; i <= 7; i++) exp_q.push_back({2'b10, 16'(i)});
        for (int i = 1; i <= 7; i++) begin
            bus.aud_valid = 1'b1;
            bus.aud_data  = 16'(i);
            tick();
        end
        bus.aud_valid = 1'b0;
        wait_drained("audio", 200);
        repeat (30) tick();
        n_vec++;
        if (n_sends != 1) begin
            n_err++;
            $display("FAIL audio_send_count: got %0d, want 1", n_sends);
        end
        n_vec++;
        if (bus.aud_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL audio_no_overflow: got %b, want 0", bus.aud_overflow);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        exp_q.push_back({2'b01, 16'hC000});
        exp_q.push_back({2'b01, 16'hC001});
        exp_q.push_back({2'b10, 16'h0055});
        exp_q.push_back({2'b01, 16'hC002});
        ctrl_words.push_back(16'hC001);
        ctrl_words.push_back(16'hC002);
        bus.aud_valid = 1'b1;
        bus.aud_data  = 16'h0055;
        bus.ctrl_data = 16'hC000;
        bus.ctrl_req  = 1'b1;
        tick();
        bus.aud_valid = 1'b0;
        wait_drained("arb", 200);
        repeat (40) tick();
        n_vec++;
        if (n_acks != 3) begin
            n_err++;
            $display("FAIL arb_acks: got %0d, want 3", n_acks);
        end
        n_vec++;
        if (n_sends != 3) begin
            n_err++;
            $display("FAIL arb_sends: got %0d, want 3", n_sends);
        end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        busy_en = 1'b0;
        exp_q.push_back({2'b01, 16'h1234});
        bus.ctrl_data = 16'h1234;
        bus.ctrl_req  = 1'b1;
        k = 0;
        while (n_acks == 0 && k < 40) begin
            tick();
            k++;
            if (n_issues == 1 && cyc - last_issue_cyc == 15) begin
                n_vec++;
                if (bus.err_timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL timeout_early: err_timeout=%b 15 cycles after issue, want 0",
                             bus.err_timeout);
                end
            end
        end
        n_vec++;
        if (n_acks != 1 || last_ack_cyc - last_issue_cyc != 16) begin
            n_err++;
            $display("FAIL timeout_ack: acks=%0d issue->ack=%0d, want 1 ack at 16",
                     n_acks, last_ack_cyc - last_issue_cyc);
        end
        n_vec++;
        if (bus.err_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_flag: got %b, want 1", bus.err_timeout);
        end
        repeat (20) tick();
        busy_en = 1'b1;
        n_vec++;
        if (n_sends != 0 || n_issues != 1) begin
            n_err++;
            $display("FAIL timeout_idle: sends=%0d issues=%0d, want 0 and 1", n_sends, n_issues);
        end
    endtask

    // Runs straight after the timeout test, so it also shows the grant FSM went back to idle.
    task automatic test_overflow();
        int sends0;
        sends0 = n_sends;
        busy_force = 1'b1;
        for (int i = 1; i <= 8; i++) exp_q.push_back({2'b10, 16'(i)});
        for (int i = 1; i <= 9; i++) begin
            bus.aud_valid = 1'b1;
            bus.aud_data  = 16'(i);
            tick();
            if (i >= 8) begin
                n_vec++;
                if (bus.aud_overflow !== (i == 9)) begin
                    n_err++;
                    $display("FAIL overflow_after_%0d: got %b, want %b",
                             i, bus.aud_overflow, (i == 9));
                end
            end
        end
        bus.aud_valid = 1'b0;
        repeat (3) tick();
        busy_force = 1'b0;
        wait_drained("overflow", 200);
        repeat (30) tick();
        n_vec++;
        if (n_sends - sends0 != 1) begin
            n_err++;
            $display("FAIL overflow_sends: got %0d, want 1", n_sends - sends0);
        end
        n_vec++;
        if (bus.err_timeout !== 1'b1 || bus.aud_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_flags: err=%b ovf=%b, want 1 and 1",
                     bus.err_timeout, bus.aud_overflow);
        end
    endtask

    task automatic test_reset_mid();
        int k, issues0, sends0;
        issues0 = n_issues;
        exp_q.push_back({2'b10, 16'h00A1});
        busy_force = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.aud_valid = 1'b1;
            bus.aud_data  = 16'h00A0 + 16'(i);
            tick();
        end
        bus.aud_valid = 1'b0;
        busy_force = 1'b0;
        k = 0;
        while (n_issues == issues0 && k < 20) begin tick(); k++; end
        n_vec++;
        if (n_issues == issues0) begin
            n_err++;
            $display("FAIL reset_mid_issue: no issue within 20 cycles, want 1");
        end
        tick();
        reset = 1'b1;
        tick();
        n_vec++;
        if ({bus.tx_cmd, bus.tx_data, bus.ctrl_ack, bus.tx_send, bus.err_timeout,
             bus.aud_overflow} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: cmd=%b data=%h ack=%b send=%b err=%b ovf=%b, want all 0",
                     bus.tx_cmd, bus.tx_data, bus.ctrl_ack, bus.tx_send, bus.err_timeout,
                     bus.aud_overflow);
        end
        tick();
        reset = 1'b0;
        issues0 = n_issues;
        sends0  = n_sends;
        repeat (40) tick();
        n_vec++;
        if (n_issues != issues0 || n_sends != sends0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: new issues=%0d sends=%0d pending=%0d, want 0 0 0",
                     n_issues - issues0, n_sends - sends0, exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ctrl_req  = 1'b0;
        bus.ctrl_data = '0;
        bus.aud_valid = 1'b0;
        bus.aud_data  = '0;
        test_reset();
        test_ctrl_word();
        test_audio_packet();
        test_arbitration();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
